// File: rtl/clock_monitor.sv
// Measures the period and high time of an asynchronous clk_in in clk cycles, and reports lock and stall status.
// High-time capture is compiled in only when CLOCK_MONITOR_DUTY_EN is defined; otherwise high_time is tied to 0.
module clock_monitor #(
    parameter int WIDTH      = 16,
    parameter int EXP_PERIOD = 4,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam int LW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0]       LOCK_MAX  = LW'(LOCK_COUNT);
    localparam logic [WIDTH-1:0]    TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0]    CNT_ONE   = WIDTH'(1);
    // One extra bit keeps EXP_PERIOD-TOL from wrapping when it goes negative.
    localparam logic signed [WIDTH:0] TOL_LO  = (WIDTH+1)'(EXP_PERIOD - TOL);
    localparam logic signed [WIDTH:0] TOL_HI  = (WIDTH+1)'(EXP_PERIOD + TOL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             rise;
    logic [WIDTH-1:0] cnt_inc;
    logic signed [WIDTH:0] cnt_ext;
    logic             in_tol;
    logic [LW-1:0]    lock_next;

`ifdef CLOCK_MONITOR_DUTY_EN
    logic             fall;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
`endif

    always_comb begin
        sync1_d    = clk_in;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        rise       = sync2_q & ~hist_q;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
        cnt_ext    = {1'b0, cnt_q};
        in_tol     = (cnt_ext >= TOL_LO) && (cnt_ext <= TOL_HI);
        lock_next  = in_tol ? ((lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LW'(1)) : '0;

        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
`ifdef CLOCK_MONITOR_DUTY_EN
        fall        = ~sync2_q & hist_q;
        shadow_d    = shadow_q;
        high_time_d = high_time_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            MEASURE: begin
                // A rise on the same cycle the counter hits TIMEOUT still completes the measurement.
                if (rise) begin
                    period_d   = cnt_q;
                    valid_d    = 1'b1;
                    cnt_d      = CNT_ONE;
                    lock_cnt_d = lock_next;
                    locked_d   = (lock_next == LOCK_MAX);
`ifdef CLOCK_MONITOR_DUTY_EN
                    high_time_d = shadow_q;
`endif
                end else if (cnt_q == TIMEOUT_W) begin
                    state_d    = STALLED;
                    timeout_d  = 1'b1;
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
`ifdef CLOCK_MONITOR_DUTY_EN
                if (fall) begin
                    shadow_d = cnt_q;
                end
`endif
            end
            STALLED: begin
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                    cnt_d     = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef CLOCK_MONITOR_DUTY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q    <= '0;
            high_time_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

    assign period  = period_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;

endmodule
